nios_practica_jtag_host_master: RTL
===================================

// Module: nios_practica_jtag_host_master
// PURPOSE
//  Clock-domain JTAG initiator: generates TCK/TMS/TDI and samples TDO to drive IR/DR scans into a
//  1149.1 TAP, e.g. the CPU debug-slave virtual JTAG (2-bit IR, 38-bit DR). Sits between a
//  command source (test bench / debug bridge) and the TAP pins; owns TAP state navigation.
//  One command = one IR or DR scan starting and ending in Run-Test/Idle (RTI).
// PARAMETERS
//  CLK_DIV   4    clk cycles per TCK half-period (>=1); TCK period = 2*CLK_DIV clk
//  MAX_LEN   38   maximum scan length in bits; data buses are MAX_LEN wide
//  LEN_W     6    width of cmd_len; must hold MAX_LEN
// PORTS
//  clk        in   1        system clock; all logic on rising edge
//  reset      in   1        asynchronous, active-high reset
//  cmd_valid  in   1        command offered
//  cmd_ready  out  1        block accepts command this cycle (valid&ready = accept)
//  cmd_is_ir  in   1        1 = IR scan, 0 = DR scan
//  cmd_len    in   LEN_W    scan length in bits, legal 1..MAX_LEN
//  cmd_data   in   MAX_LEN  TDI bits, bit0 shifted first
//  rsp_valid  out  1        scan result available; held until rsp_ready
//  rsp_ready  in   1        result consumed (valid&ready = pop)
//  rsp_data   out  MAX_LEN  captured TDO, bit0 = first bit captured; bits >= len are 0
//  rsp_err    out  1        command rejected (illegal length); rsp_data = 0
//  tck        out  1        JTAG clock
//  tms        out  1        JTAG mode select
//  tdi        out  1        JTAG data to TAP
//  tdo        in   1        JTAG data from TAP (synchronous to generated tck)
// BEHAVIOUR
//  Reset values: tck=0 tms=1 tdi=0 cmd_ready=0 rsp_valid=0 rsp_data=0 rsp_err=0.
//  Timing: tck toggles every CLK_DIV clk while a scan is active; tck idles low otherwise.
//   tms/tdi update in the clk cycle tck falls (or at TCK-cycle start); tdo is sampled in the
//   clk cycle tck rises. Each TCK cycle = one TMS value = one TAP transition.
//  FSM: TLR_SEQ -> IDLE -> NAV -> SHIFT -> EXIT -> RESP -> IDLE.
//   TLR_SEQ: entered on reset release; 5 TCK cycles TMS=1 then 1 TCK cycle TMS=0 (TAP in RTI);
//            cmd_ready=0 throughout.
//   IDLE: cmd_ready=1 iff rsp_valid=0. On accept, latch cmd_is_ir/len/data; cmd_ready drops
//         the next cycle. Illegal len (0 or >MAX_LEN): no TCK activity, go to RESP with
//         rsp_err=1.
//   NAV: TMS sequence DR=1,0,0 ; IR=1,1,0,0 (RTI->Shift-xR); tdi=0.
//   SHIFT: len TCK cycles; tdi=data[i]; TMS=0, except TMS=1 on last bit (-> Exit1-xR);
//          tdo sampled on each rising edge into bit i, i=0..len-1.
//   EXIT: TMS=1 (Update-xR), then TMS=0 (RTI); tms left 0 at end.
//   RESP: rsp_valid=1, rsp_data/rsp_err stable until rsp_ready; then IDLE.
//  Scan lengths: DR = len+5 TCK cycles, IR = len+6 TCK cycles from accept to RESP.
//  Latency: accept to rsp_valid = (TCKcycles*2*CLK_DIV)+1 clk (±1 clk fixed, documented in RTL).
//  Back-to-back: cmd_ready stays 0 until response popped; no command queueing.
//  Command inputs ignored while not in IDLE; cmd_valid may drop without being accepted.
//  Reset mid-scan: asynchronous abort, outputs to reset values, pending rsp discarded,
//   TLR_SEQ rerun after release.
//  cmd_len=MAX_LEN: full width used, no overflow; cmd_len=1: single-bit scan, TMS=1 on it.
//  rsp_valid & rsp_ready in the same cycle as a new cmd_valid: pop only; accept next cycle.
// TESTING
//  1 Reset release, CLK_DIV=4 -> 6 tck rising edges TMS=1,1,1,1,1,0; cmd_ready=1 after 48+ clk.
//  2 DR scan len=38 data=38'h2A_5555_AAAA, TAP model echoes TDI -> 43 tck pulses,
//    rsp_data=38'h2A_5555_AAAA, rsp_err=0.
//  3 IR scan len=2 data=2'b10, TAP model -> TMS 1,1,0,0,0,1,1,0 on rises; IR register = 2'b10.
//  4 cmd_len=0 and cmd_len=39 -> rsp_err=1, rsp_data=0, zero tck edges.
//  5 rsp_ready held 0 for 100 clk -> rsp_valid/rsp_data stable, cmd_ready=0, no tck activity.
//  6 reset asserted after 10th SHIFT bit -> tck=0 tms=1 immediately, no rsp_valid; after
//    release, TLR_SEQ reruns and next DR scan len=1 completes correctly.

Source files
------------

// File: rtl/nios_practica_jtag_host_master.sv
// JTAG initiator: turns IR/DR scan commands into TCK/TMS/TDI sequences and returns captured TDO.
// Latency accept->rsp_valid = TCKcycles*2*CLK_DIV+1 clk; cmd_ready held low until the response is popped.
module nios_practica_jtag_host_master #(
  parameter int CLK_DIV = 4,
  parameter int MAX_LEN = 38,
  parameter int LEN_W   = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_is_ir,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               rsp_err,
  output logic               tck,
  output logic               tms,
  output logic               tdi,
  input  logic               tdo
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {
    S_TLR, S_IDLE, S_NAV, S_SHIFT, S_EXIT, S_RESP
  } state_t;

  state_t             state, state_next;
  logic [CW-1:0]      div_cnt;
  logic [LEN_W-1:0]   step;
  logic               is_ir_q;
  logic [LEN_W-1:0]   len_q;
  logic [MAX_LEN-1:0] data_q;
  logic [MAX_LEN-1:0] cap_q;
  logic               err_q;

  logic active;
  logic half_end;
  logic tck_rise;
  logic tck_fall;
  logic last_step;
  logic cmd_ok;
  logic accept;

  assign active   = (state == S_TLR) || (state == S_NAV) ||
                    (state == S_SHIFT) || (state == S_EXIT);
  assign half_end = (div_cnt == CW'(CLK_DIV - 1));
  assign tck_rise = active && !tck && half_end;
  // A TCK cycle ends on the clk edge where tck falls; that is where the sequence advances.
  assign tck_fall = active && tck && half_end;
  assign cmd_ok   = (cmd_len != '0) && (cmd_len <= LEN_W'(MAX_LEN));
  assign accept   = cmd_valid && cmd_ready;

  always_comb begin
    last_step = 1'b0;
    case (state)
      S_TLR:   last_step = (step == LEN_W'(5));
      S_NAV:   last_step = (step == (is_ir_q ? LEN_W'(3) : LEN_W'(2)));
      S_SHIFT: last_step = (step == len_q - LEN_W'(1));
      S_EXIT:  last_step = (step == LEN_W'(1));
      default: last_step = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_TLR;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_TLR:   if (tck_fall && last_step) state_next = S_IDLE;
      S_IDLE:  if (accept) state_next = cmd_ok ? S_NAV : S_RESP;
      S_NAV:   if (tck_fall && last_step) state_next = S_SHIFT;
      S_SHIFT: if (tck_fall && last_step) state_next = S_EXIT;
      S_EXIT:  if (tck_fall && last_step) state_next = S_RESP;
      S_RESP:  if (rsp_ready) state_next = S_IDLE;
      default: state_next = S_TLR;
    endcase
  end

  always_comb begin
    tms       = 1'b0;
    tdi       = 1'b0;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_data  = '0;
    rsp_err   = 1'b0;
    case (state)
      S_TLR:   tms = (step < LEN_W'(5));
      S_IDLE:  cmd_ready = 1'b1;
      S_NAV:   tms = (step == '0) || (is_ir_q && (step == LEN_W'(1)));
      S_SHIFT: begin
        tms = last_step;
        tdi = data_q[step];
      end
      S_EXIT:  tms = (step == '0);
      S_RESP: begin
        rsp_valid = 1'b1;
        rsp_data  = cap_q;
        rsp_err   = err_q;
      end
      default: tms = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      tck     <= 1'b0;
      step    <= '0;
      is_ir_q <= 1'b0;
      len_q   <= '0;
      data_q  <= '0;
      cap_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      if (active) begin
        if (half_end) begin
          div_cnt <= '0;
          tck     <= ~tck;
        end else begin
          div_cnt <= div_cnt + CW'(1);
        end
      end else begin
        div_cnt <= '0;
        tck     <= 1'b0;
      end

      if (state_next != state) step <= '0;
      else if (tck_fall)       step <= step + LEN_W'(1);

      if (tck_rise && (state == S_SHIFT)) cap_q[step] <= tdo;

      if (accept) begin
        is_ir_q <= cmd_is_ir;
        len_q   <= cmd_len;
        data_q  <= cmd_data;
        cap_q   <= '0;
        err_q   <= !cmd_ok;
      end
    end
  end

endmodule
